// File: rtl/bist_pkg.sv
// bist_pkg: shared FSM states, default LFSR constants and chain-tap indexing for the BIST generator.
package bist_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;
  localparam int DEFAULT_LFSR_WIDTH = 8;
  localparam logic [7:0] DEFAULT_POLY = 8'h1D;
  // Chain i taps lfsr[(width-1-i*stride) mod width]; the double modulo keeps the index non-negative.
  function automatic int chain_tap(input int width, input int stride, input int idx);
    return (((width - 1 - idx * stride) % width) + width) % width;
  endfunction
endpackage

// File: rtl/bist_lfsr_core.sv
// bist_lfsr_core: parametrised XNOR LFSR with load/advance/hold control and per-chain output taps.
// With BIST_LOCKUP_RECOVER_EN defined it also reports the all-ones lock-up state on all_ones.
module bist_lfsr_core
  import bist_pkg::*;
#(
  parameter int W = DEFAULT_LFSR_WIDTH,
  parameter logic [W-1:0] POLY = DEFAULT_POLY,
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_STRIDE = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [W-1:0]          load_value,
`ifdef BIST_LOCKUP_RECOVER_EN
  output logic                  all_ones,
`endif
  output logic [NUM_CHAINS-1:0] scan_in
);
  logic [W-1:0] lfsr;
  always_ff @(posedge clock)
    if (reset) lfsr <= '0;
    else if (load) lfsr <= load_value;
    else if (advance) lfsr <= {lfsr[W-2:0], ~^(lfsr & POLY)};
  for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_tap
    assign scan_in[g] = lfsr[chain_tap(W, CHAIN_STRIDE, g)];
  end
`ifdef BIST_LOCKUP_RECOVER_EN
  assign all_ones = &lfsr;
`endif
endmodule

// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: multi-chain BIST pattern generator with seed load, pattern counter and shift/capture sequencer.
// Define BIST_LOCKUP_RECOVER_EN to reseed out of the all-ones lock-up state and report it on lockup_seen.
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int LFSR_WIDTH = DEFAULT_LFSR_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] POLY = DEFAULT_POLY,
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_STRIDE = 2,
  parameter int CHAIN_LEN = 16,
  parameter int PCNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic [PCNT_W-1:0]     num_patterns,
  output logic [NUM_CHAINS-1:0] scan_in,
  output logic                  scan_en,
  output logic                  capture,
  output logic                  busy,
  output logic                  done,
`ifdef BIST_LOCKUP_RECOVER_EN
  output logic                  lockup_seen,
`endif
  output logic [PCNT_W-1:0]     pattern_idx
);
  localparam int CW = CHAIN_LEN > 1 ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
  if (NUM_CHAINS > LFSR_WIDTH || NUM_CHAINS < 1 || POLY == '0 || LFSR_WIDTH < 3 || CHAIN_LEN < 1) begin : g_cfg_err
    $error("bist_pattern_gen: need 1<=NUM_CHAINS<=LFSR_WIDTH, POLY!=0, LFSR_WIDTH>=3, CHAIN_LEN>=1");
  end
  state_t state;
  logic [CW-1:0] shift_cnt;
  logic [PCNT_W-1:0] num_q;
  logic [LFSR_WIDTH-1:0] load_value;
  logic accept, load;
  assign accept = state == IDLE && start;
`ifdef BIST_LOCKUP_RECOVER_EN
  logic [LFSR_WIDTH-1:0] seed_q;
  logic all_ones, lockup, lockup_q;
  assign lockup = state == SHIFT && all_ones;
  assign load = accept || lockup;
  // Recovery reloads the seed with bit 0 flipped; an all-ones seed would relock, so use zero instead.
  assign load_value = accept ? seed : &seed_q ? '0 : seed_q ^ LFSR_WIDTH'(1);
  assign lockup_seen = lockup_q || lockup;
  always_ff @(posedge clock)
    if (reset) begin
      seed_q <= '0;
      lockup_q <= 1'b0;
    end else if (accept) begin
      seed_q <= seed;
      lockup_q <= 1'b0;
    end else if (lockup) lockup_q <= 1'b1;
`else
  assign load = accept;
  assign load_value = seed;
`endif
  bist_lfsr_core #(
    .W(LFSR_WIDTH), .POLY(POLY), .NUM_CHAINS(NUM_CHAINS), .CHAIN_STRIDE(CHAIN_STRIDE)
  ) u_core (
    .clock(clock),
    .reset(reset),
    .load(load),
    .advance(state == SHIFT),
    .load_value(load_value),
`ifdef BIST_LOCKUP_RECOVER_EN
    .all_ones(all_ones),
`endif
    .scan_in(scan_in)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      shift_cnt <= '0;
      pattern_idx <= '0;
      num_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          num_q <= num_patterns;
          pattern_idx <= '0;
          shift_cnt <= '0;
          state <= num_patterns == '0 ? DONE : SHIFT;
        end
        SHIFT: begin
          shift_cnt <= shift_cnt == LAST ? '0 : shift_cnt + 1'b1;
          if (shift_cnt == LAST) state <= CAPTURE;
        end
        CAPTURE: if (pattern_idx == num_q - 1'b1) state <= DONE;
        else begin
          pattern_idx <= pattern_idx + 1'b1;
          state <= SHIFT;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  assign scan_en = state == SHIFT;
  assign capture = state == CAPTURE;
  assign done = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_bist_pattern_gen.sv
// tb_bist_pattern_gen: directed self-checking bench for bist_pattern_gen at default parameters.
module tb_bist_pattern_gen;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] seed = '0;
  logic [15:0] num_patterns = '0;
  logic [3:0] scan_in;
  logic scan_en, capture, busy, done;
  logic [15:0] pattern_idx;
`ifdef BIST_LOCKUP_RECOVER_EN
  logic lockup_seen;
`endif
  int n_err = 0, n_checks = 0;
  int cap_t[$];
  logic [15:0] cap_idx[$];
  logic [3:0] trace[$];
  logic [7:0] ltrace[$];
  int n_scan, done_t;
  bit busy_drop;
  logic [7:0] seq0 [7] = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h0B, 8'h17, 8'h2E};

  always #5 clock = ~clock;

  bist_pattern_gen dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .seed(seed),
    .num_patterns(num_patterns),
    .scan_in(scan_in),
    .scan_en(scan_en),
    .capture(capture),
    .busy(busy),
    .done(done),
`ifdef BIST_LOCKUP_RECOVER_EN
    .lockup_seen(lockup_seen),
`endif
    .pattern_idx(pattern_idx)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] l);
    return {l[6:0], ~^(l & 8'h1D)};
  endfunction

  function automatic logic [3:0] taps(input logic [7:0] l);
    return {l[1], l[3], l[5], l[7]};
  endfunction

  // Launch a run and record one entry per cycle from the busy rising edge through the done cycle.
  task automatic run(input logic [7:0] s, input logic [15:0] n, input int restart_at);
    seed = s;
    num_patterns = n;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cap_t.delete();
    cap_idx.delete();
    trace.delete();
    ltrace.delete();
    n_scan = 0;
    done_t = -1;
    busy_drop = 1'b0;
    for (int t = 0; t < 2000 && done_t < 0; t++) begin
      if (t == restart_at) start = 1'b1;
      if (!busy) busy_drop = 1'b1;
      if (scan_en) n_scan++;
      if (capture) begin
        cap_t.push_back(t);
        cap_idx.push_back(pattern_idx);
      end
      trace.push_back(scan_in);
      ltrace.push_back(dut.u_core.lfsr);
      if (done) done_t = t;
      @(negedge clock);
      start = 1'b0;
    end
    check("run_timeout", 64'(done_t < 0), 0);
    check("run_busy_drop", 64'(busy_drop), 0);
    check("idle_after_done", 64'(busy), 0);
  endtask

  // Compare the recorded lfsr/scan_in trace with a model that holds on every 17th (capture) cycle.
  task automatic check_trace(input string tag, input logic [7:0] s);
    logic [7:0] l = s;
    int bad = -1;
    for (int t = 0; t < ltrace.size(); t++) begin
      if (bad < 0 && (ltrace[t] !== l || trace[t] !== taps(l))) bad = t;
`ifdef BIST_LOCKUP_RECOVER_EN
      if (t % 17 != 16) l = l == 8'hFF ? (s == 8'hFF ? 8'h00 : s ^ 8'h01) : nxt(l);
`else
      if (t % 17 != 16) l = nxt(l);
`endif
    end
    check(tag, 64'(bad + 1), 0);
  endtask

  initial begin
    logic [3:0] first_trace[$];
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(busy), 0);
    check("rst_outs", {scan_en, capture, done, scan_in}, 0);
    check("rst_lfsr", 64'(dut.u_core.lfsr), 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_hold", {busy, pattern_idx}, 0);

    run(8'h00, 16'd1, -1);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("seq0_lfsr%0d", i), 64'(ltrace[i]), 64'(seq0[i]));
      check($sformatf("seq0_si0_%0d", i), 64'(trace[i][0]), 0);
    end
    check("p1_scan_en", 64'(n_scan), 16);
    check("p1_ncap", 64'(cap_t.size()), 1);
    check("p1_cap_t", 64'(cap_t[0]), 16);
    check("p1_done_t", 64'(done_t), 17);
    check_trace("p1_trace", 8'h00);

    run(8'h5A, 16'd3, -1);
    check("p3_ncap", 64'(cap_t.size()), 3);
    for (int i = 0; i < 3 && i < cap_t.size(); i++) begin
      check($sformatf("p3_cap_t%0d", i), 64'(cap_t[i]), 64'(16 + 17 * i));
      check($sformatf("p3_idx%0d", i), 64'(cap_idx[i]), 64'(i));
    end
    check("p3_scan_en", 64'(n_scan), 48);
    check("p3_done_t", 64'(done_t), 51);
    check_trace("p3_trace", 8'h5A);

    run(8'h77, 16'd0, -1);
    check("p0_done_t", 64'(done_t), 0);
    check("p0_quiet", 64'(n_scan + cap_t.size()), 0);

    run(8'h3C, 16'd2, 5);
    check("rs_done_t", 64'(done_t), 34);
    check("rs_ncap", 64'(cap_t.size()), 2);
    check_trace("rs_trace", 8'h3C);
    first_trace = trace;
    run(8'h3C, 16'd2, -1);
    check("rep_done_t", 64'(done_t), 34);
    check_trace("rep_trace", 8'h3C);
    check("rep_len", 64'(trace.size()), 64'(first_trace.size()));

    seed = 8'h00;
    num_patterns = 16'd1;
    start = 1'b1;
    @(negedge clock);
    for (int t = 0; t < 100 && !done; t++) @(negedge clock);
    check("hold_done", 64'(done), 1);
    @(negedge clock);
    check("hold_idle", 64'(busy), 0);
    @(negedge clock);
    check("hold_relaunch", {busy, scan_en, dut.u_core.lfsr}, {1'b1, 1'b1, 8'h00});
    start = 1'b0;
    for (int t = 0; t < 100 && !done; t++) @(negedge clock);
    @(negedge clock);
    check("hold_end_idle", 64'(busy), 0);

    seed = 8'h11;
    num_patterns = 16'd3;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (22) @(negedge clock);
    check("mid_pos", {pattern_idx, scan_en}, {16'd1, 1'b1});
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_outs", {busy, scan_en, capture, done, scan_in}, 0);
    check("mid_rst_idx", 64'(pattern_idx), 0);
    check("mid_rst_lfsr", 64'(dut.u_core.lfsr), 0);
    reset = 1'b0;
    @(negedge clock);

`ifdef BIST_LOCKUP_RECOVER_EN
    begin
      bit saw_ff = 1'b0;
      seed = 8'hFF;
      num_patterns = 16'd1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("lk_first", {lockup_seen, dut.u_core.lfsr}, {1'b1, 8'hFF});
      @(negedge clock);
      check("lk_reload", 64'(dut.u_core.lfsr), 0);
      for (int t = 0; t < 15; t++) begin
        if (dut.u_core.lfsr == 8'hFF) saw_ff = 1'b1;
        @(negedge clock);
      end
      check("lk_no_ff", 64'(saw_ff), 0);
      check("lk_sticky", 64'(lockup_seen), 1);
      for (int t = 0; t < 100 && busy; t++) @(negedge clock);
      run(8'h00, 16'd1, -1);
      check("lk_cleared", 64'(lockup_seen), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
